cpu_sequencer: RTL and testbench

- Control FSM that sequences each instruction through fetch, decode, optional data-memory access and execute/commit.
- Shares the single memory port between instruction fetch (address = IP) and data access (address = ALU result).
- Owns the interrupt-enable flag and injects the INT instruction at instruction boundaries.
- Sits between the instruction register/decoder and the register/stack datapath. Consumes decoder memory/IEN controls; produces phase strobes for the datapath.

---
 rtl/cpu_seq_pkg.sv | 31 +++
 rtl/sync_ff.sv | 29 ++
 rtl/cpu_sequencer.sv | 147 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package cpu_seq_pkg;

  // Sequencer phases; IDLE must be code 0 so reset reads back as zero.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4
  } seq_state_t;

  localparam int unsigned INSN_W = 16;
  localparam int unsigned BE_W   = 2;

  // Encoding that decodes as INT, loaded into the IR on interrupt injection.
  localparam logic [INSN_W-1:0] INT_INSN_DEF = 16'h7810;

  // Byte-lane enables, little-endian.
  localparam logic [BE_W-1:0] BE_NONE = 2'b00;
  localparam logic [BE_W-1:0] BE_WORD = 2'b11;
  localparam logic [BE_W-1:0] BE_LO   = 2'b01;
  localparam logic [BE_W-1:0] BE_HI   = 2'b10;

  // Lane select for a data access given size and address bit 0.
  function automatic logic [BE_W-1:0] data_byte_en(input logic byt, input logic lsb);
    if (!byt) return BE_WORD;
    return lsb ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input.
module sync_ff #(
  parameter int unsigned DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  // Fewer than two flops gives no metastability settling time.
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_ff: DEPTH must be at least 2");
  end

  logic [DEPTH-1:0] r_sync;

  // Shift chain: the input enters at bit 0 and leaves from the top bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch / decode / data access / commit, with a
// shared memory port and interrupt injection at instruction boundaries.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [INSN_W-1:0] INT_INSN        = INT_INSN_DEF,
  parameter logic              IEN_RESET       = 1'b0,
  parameter int unsigned       IRQ_SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_rd_mem,
  input  logic            dec_wr_mem,
  input  logic            dec_byt,
  input  logic            dec_set_ien,
  input  logic            dec_clear_ien,
  input  logic            data_addr_lsb,
  input  logic            irq,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic [BE_W-1:0] mem_byte_en,
  output logic            insn_load,
  output logic            int_inject,
  output logic            exec_en,
  output logic            irq_ack,
  output logic            ien,
  output logic [2:0]      state_dbg
);

  // The IR loads INT_INSN on int_inject; an all-zero encoding could not be
  // told apart from a cleared instruction register.
  if (INT_INSN == '0) begin : g_bad_int_insn
    $error("cpu_sequencer: INT_INSN must be non-zero");
  end

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic       r_fetch_busy;
  logic       w_fetch_busy_nxt;
  logic       r_ien;
  logic       w_ien_nxt;
  logic       w_irq_s;
  logic       w_take_irq;

  // Bring the asynchronous irq level into the clock domain.
  sync_ff #(
    .DEPTH (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (irq),
    .o_q   (w_irq_s)
  );

  // Interrupt is only taken on the first cycle of a fetch, never mid-request.
  assign w_take_irq = (r_state == ST_FETCH) && !r_fetch_busy && w_irq_s && r_ien;

  // State, outstanding-fetch flag and interrupt enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_fetch_busy <= 1'b0;
      r_ien        <= IEN_RESET;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_busy <= w_fetch_busy_nxt;
      r_ien        <= w_ien_nxt;
    end
  end

  // Next-state and phase-strobe decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_busy_nxt = 1'b0;
    w_ien_nxt        = r_ien;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr_sel     = 1'b0;
    mem_byte_en      = BE_NONE;
    insn_load        = 1'b0;
    int_inject       = 1'b0;
    exec_en          = 1'b0;
    irq_ack          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (w_take_irq) begin
          // Inject INT in place of a fetch; no memory cycle is spent.
          insn_load   = 1'b1;
          int_inject  = 1'b1;
          irq_ack     = 1'b1;
          w_ien_nxt   = 1'b0;
          w_state_nxt = ST_DECODE;
        end else begin
          mem_req     = 1'b1;
          mem_byte_en = BE_WORD;
          if (mem_ack) begin
            insn_load   = 1'b1;
            w_state_nxt = ST_DECODE;
          end else begin
            w_fetch_busy_nxt = 1'b1;
          end
        end
      end

      ST_DECODE: begin
        w_state_nxt = (dec_rd_mem || dec_wr_mem) ? ST_MEM : ST_EXEC;
      end

      ST_MEM: begin
        // Write wins when both read and write are decoded.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_wr_mem;
        mem_byte_en  = data_byte_en(dec_byt, data_addr_lsb);
        if (mem_ack) begin
          w_state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Clear beats set so a conflicting decode never leaves interrupts on.
        exec_en     = 1'b1;
        w_state_nxt = ST_FETCH;
        if (dec_clear_ien) begin
          w_ien_nxt = 1'b0;
        end else if (dec_set_ien) begin
          w_ien_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ien       = r_ien;
  assign state_dbg = 3'(r_state);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Table-driven check of the sequencer with a queue of expected outputs.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_rd_mem, dec_wr_mem, dec_byt, dec_set_ien, dec_clear_ien;
  logic       data_addr_lsb, irq, mem_ack;
  logic       mem_req, mem_we, mem_addr_sel, insn_load, int_inject;
  logic       exec_en, irq_ack, ien;
  logic [1:0] mem_byte_en;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // stim = {rst, rd, wr, byt, set, clr, lsb, irq, ack}
  // expv = {state[2:0], req, we, sel, be[1:0], ld, inj, exec, iack, ien}
  typedef struct packed {
    logic [8:0]  stim;
    logic [12:0] expv;
  } vec_t;

  vec_t        tbl[$];
  logic [12:0] sb_q[$];

  always #5 clk = ~clk;

  cpu_sequencer #(
    .INT_INSN        (16'h7810),
    .IEN_RESET       (1'b0),
    .IRQ_SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_rd_mem    (dec_rd_mem),
    .dec_wr_mem    (dec_wr_mem),
    .dec_byt       (dec_byt),
    .dec_set_ien   (dec_set_ien),
    .dec_clear_ien (dec_clear_ien),
    .data_addr_lsb (data_addr_lsb),
    .irq           (irq),
    .mem_ack       (mem_ack),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr_sel  (mem_addr_sel),
    .mem_byte_en   (mem_byte_en),
    .insn_load     (insn_load),
    .int_inject    (int_inject),
    .exec_en       (exec_en),
    .irq_ack       (irq_ack),
    .ien           (ien),
    .state_dbg     (state_dbg)
  );

  function automatic logic [8:0] in8(input logic rd, input logic wr, input logic byt,
                                     input logic set, input logic clr, input logic lsb,
                                     input logic irqv, input logic ack);
    return {1'b0, rd, wr, byt, set, clr, lsb, irqv, ack};
  endfunction

  function automatic logic [12:0] ex(input seq_state_t st, input logic req, input logic we,
                                     input logic sel, input logic [1:0] be, input logic ld,
                                     input logic inj, input logic exn, input logic iack,
                                     input logic ienv);
    return {3'(st), req, we, sel, be, ld, inj, exn, iack, ienv};
  endfunction

  function automatic logic [12:0] e_idle(input logic ienv);
    return ex(ST_IDLE, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ienv);
  endfunction
  function automatic logic [12:0] e_fetch(input logic ack, input logic ienv);
    return ex(ST_FETCH, 1'b1, 1'b0, 1'b0, 2'b11, ack, 1'b0, 1'b0, 1'b0, ienv);
  endfunction
  function automatic logic [12:0] e_inj(input logic ienv);
    return ex(ST_FETCH, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, ienv);
  endfunction
  function automatic logic [12:0] e_dec(input logic ienv);
    return ex(ST_DECODE, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ienv);
  endfunction
  function automatic logic [12:0] e_mem(input logic we, input logic [1:0] be, input logic ienv);
    return ex(ST_MEM, 1'b1, we, 1'b1, be, 1'b0, 1'b0, 1'b0, 1'b0, ienv);
  endfunction
  function automatic logic [12:0] e_exec(input logic ienv);
    return ex(ST_EXEC, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, ienv);
  endfunction

  task automatic add(input logic [8:0] s, input logic [12:0] e);
    vec_t v;
    v.stim = s;
    v.expv = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [8:0] s);
    {rst, dec_rd_mem, dec_wr_mem, dec_byt, dec_set_ien, dec_clear_ien,
     data_addr_lsb, irq, mem_ack} = s;
  endtask

  // Pop the oldest expectation and compare against the live outputs.
  task automatic check(input string nm);
    logic [12:0] got;
    logic [12:0] want;
    got = {state_dbg, mem_req, mem_we, mem_addr_sel, mem_byte_en,
           insn_load, int_inject, exec_en, irq_ack, ien};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, got=%h", nm, got);
    end else begin
      want = sb_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", nm, got, want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(9'b1_0000_0000);

    // Reset release with zero-wait memory: IDLE, then FETCH/DECODE/EXEC.
    add(in8(0,0,0,0,0,0,0,1), e_idle(0));
    add(in8(0,0,0,0,0,0,0,1), e_fetch(1,0));
    add(in8(0,0,0,0,0,0,0,1), e_dec(0));
    add(in8(0,0,0,0,0,0,0,1), e_exec(0));
    add(in8(0,0,0,0,0,0,0,1), e_fetch(1,0));
    add(in8(0,0,0,0,0,0,0,1), e_dec(0));
    add(in8(0,0,0,0,0,0,0,1), e_exec(0));
    // Fetch ack delayed four cycles; load only in the ack cycle.
    for (int k = 0; k < 4; k++) add(in8(0,0,0,0,0,0,0,0), e_fetch(0,0));
    add(in8(0,0,0,0,0,0,0,1), e_fetch(1,0));
    add(in8(0,0,0,0,0,0,0,1), e_dec(0));
    add(in8(0,0,0,0,0,0,0,0), e_exec(0));
    // Byte write, high lane, one wait state in MEM.
    add(in8(0,1,1,0,0,1,0,1), e_fetch(1,0));
    add(in8(0,1,1,0,0,1,0,0), e_dec(0));
    add(in8(0,1,1,0,0,1,0,0), e_mem(1,2'b10,0));
    add(in8(0,1,1,0,0,1,0,1), e_mem(1,2'b10,0));
    add(in8(0,1,1,0,0,1,0,0), e_exec(0));
    // Byte write, low lane.
    add(in8(0,1,1,0,0,0,0,1), e_fetch(1,0));
    add(in8(0,1,1,0,0,0,0,1), e_dec(0));
    add(in8(0,1,1,0,0,0,0,1), e_mem(1,2'b01,0));
    add(in8(0,1,1,0,0,0,0,1), e_exec(0));
    // Word read.
    add(in8(1,0,0,0,0,1,0,1), e_fetch(1,0));
    add(in8(1,0,0,0,0,1,0,1), e_dec(0));
    add(in8(1,0,0,0,0,1,0,1), e_mem(0,2'b11,0));
    add(in8(1,0,0,0,0,1,0,1), e_exec(0));
    // Read and write together: write wins.
    add(in8(1,1,0,0,0,0,0,1), e_fetch(1,0));
    add(in8(1,1,0,0,0,0,0,1), e_dec(0));
    add(in8(1,1,0,0,0,0,0,1), e_mem(1,2'b11,0));
    add(in8(1,1,0,0,0,0,0,1), e_exec(0));
    // Set and clear together leave ien off; set alone turns it on.
    add(in8(0,0,0,0,0,0,0,1), e_fetch(1,0));
    add(in8(0,0,0,0,0,0,0,1), e_dec(0));
    add(in8(0,0,0,1,1,0,0,1), e_exec(0));
    add(in8(0,0,0,0,0,0,0,1), e_fetch(1,0));
    add(in8(0,0,0,0,0,0,0,1), e_dec(0));
    add(in8(0,0,0,1,0,0,0,1), e_exec(0));
    add(in8(0,0,0,0,0,0,0,1), e_fetch(1,1));
    add(in8(0,0,0,0,0,0,0,1), e_dec(1));
    add(in8(0,0,0,0,0,0,0,1), e_exec(1));
    // irq rises mid-fetch: that fetch completes normally.
    add(in8(0,0,0,0,0,0,1,0), e_fetch(0,1));
    add(in8(0,0,0,0,0,0,1,0), e_fetch(0,1));
    add(in8(0,0,0,0,0,0,1,1), e_fetch(1,1));
    add(in8(0,0,0,0,0,0,1,1), e_dec(1));
    add(in8(0,0,0,0,0,0,1,1), e_exec(1));
    // Injection at the next boundary; a stray ack is ignored.
    add(in8(0,0,0,0,0,0,1,1), e_inj(1));
    add(in8(0,0,0,0,0,0,1,1), e_dec(0));
    add(in8(0,0,0,1,0,0,1,1), e_exec(0));
    // Level still high after re-enable: injects again.
    add(in8(0,0,0,0,0,0,1,1), e_inj(1));
    add(in8(0,0,0,0,0,0,0,1), e_dec(0));
    add(in8(0,0,0,1,0,0,0,1), e_exec(0));
    // irq gone through the synchronizer: ordinary fetch.
    add(in8(0,0,0,0,0,0,0,1), e_fetch(1,1));
    add(in8(0,0,0,0,0,0,0,1), e_dec(1));
    add(in8(0,0,0,1,0,0,0,1), e_exec(1));
    // Word write left waiting in MEM for the reset sequence below.
    add(in8(0,1,0,0,0,0,0,1), e_fetch(1,1));
    add(in8(0,1,0,0,0,0,0,0), e_dec(1));
    add(in8(0,1,0,0,0,0,0,0), e_mem(1,2'b11,1));

    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(e_idle(0));
    @(negedge clk);
    check("reset_state");
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stim);
      sb_q.push_back(tbl[i].expv);
      @(negedge clk);
      check($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end

    // Still waiting on the data ack.
    drive(in8(0,1,0,0,0,0,0,0));
    sb_q.push_back(e_mem(1,2'b11,1));
    @(negedge clk);
    check("mem_wait");
    @(posedge clk);
    #3;
    // Reset mid-request must drop everything without a clock edge.
    rst = 1'b1;
    #1;
    sb_q.push_back(e_idle(0));
    check("async_rst");
    repeat (2) @(posedge clk);
    #1;
    drive(in8(0,0,0,0,0,0,0,1));
    sb_q.push_back(e_idle(0));
    @(negedge clk);
    check("post_rst_idle");
    @(posedge clk);
    #1;
    sb_q.push_back(e_fetch(1,0));
    @(negedge clk);
    check("post_rst_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
